// File: rtl/ram_pkg.sv
// Shared RAM BIST types, default geometry and the test pattern function.
// Used by ram_bist; build with ERR_CAPTURE_EN to add first-error capture.
package ram_pkg;

  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DATA_W = 8;
  localparam int DEPTH      = 2 ** RAM_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  // Callers truncate to their data width, which gives the modulo wrap.
  function automatic logic [31:0] pattern(
    input logic [31:0] a,
    input logic [31:0] s
  );
    return ((a << 1) + 32'd2) ^ s;
  endfunction

endpackage

// File: rtl/ram_bist.sv
// Write-then-read RAM self test with a seeded address pattern.
// Define ERR_CAPTURE_EN to add err_addr/err_data first-mismatch capture.
module ram_bist
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_out
`ifdef ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data
`endif
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] exp_q;
  logic              cmp_q;
  logic              fail;
  logic              pass_q;
  logic              mism;
  logic              accept;

  function automatic logic [DATA_W-1:0] pat_of(
    input logic [ADDR_W-1:0] a
  );
    return DATA_W'(pattern(32'(a), 32'(seed_q)));
  endfunction

  assign accept   = (state == IDLE) && start;
  assign mism     = cmp_q && (mem_out != exp_q);
  assign mem_addr = addr;
  assign pass     = pass_q;

  always_comb begin
    state_n  = state;
    addr_n   = addr;
    mem_rw   = 1'b0;
    mem_data = '0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = WRITE;
      end
      WRITE: begin
        mem_rw   = 1'b1;
        mem_data = pat_of(addr);
        addr_n   = addr + 1'b1;
        if (addr == LAST) state_n = READ;
      end
      READ: begin
        addr_n = addr + 1'b1;
        if (addr == LAST) state_n = DRAIN;
      end
      DRAIN: state_n = DONE;
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
    end
  end

  // Read data lags the address by one cycle, so the compare does too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q <= '0;
      exp_q  <= '0;
      cmp_q  <= 1'b0;
      fail   <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      cmp_q <= (state == READ);
      exp_q <= pat_of(addr);
      if (accept) begin
        seed_q <= seed;
        fail   <= 1'b0;
        pass_q <= 1'b0;
      end else begin
        if (mism) fail <= 1'b1;
        if (state == DRAIN) pass_q <= !(fail || mism);
      end
    end
  end

`ifdef ERR_CAPTURE_EN
  logic [ADDR_W-1:0] cmp_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_addr_q <= '0;
      err_addr   <= '0;
      err_data   <= '0;
    end else begin
      cmp_addr_q <= addr;
      if (accept) begin
        err_addr <= '0;
        err_data <= '0;
      end else if (mism && !fail) begin
        err_addr <= cmp_addr_q;
        err_data <= mem_out;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_bist.sv
// Randomized bench for ram_bist with a behavioural RAM and fault injection.
// Define ERR_CAPTURE_EN to also check the first-error capture outputs.
module tb_ram_bist;

  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int DEP = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] seed = '0;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_rw;
  logic [DW-1:0] mem_out = '0;
`ifdef ERR_CAPTURE_EN
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data;
`endif

  logic [DW-1:0] ram [DEP];
  logic          stuck0 = 1'b0;
  logic          flip_en = 1'b0;
  logic [AW-1:0] flip_addr = '0;
  logic [DW-1:0] flip_mask = '0;

  int checks = 0;
  int errors = 0;

  ram_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .seed     (seed),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_rw   (mem_rw),
    .mem_out  (mem_out)
`ifdef ERR_CAPTURE_EN
    ,
    .err_addr (err_addr),
    .err_data (err_data)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic [DW-1:0] rd;
    rd = ram[mem_addr];
    if (flip_en && mem_addr == flip_addr) rd = rd ^ flip_mask;
    if (stuck0) rd[0] = 1'b1;
    mem_out <= rd;
    if (mem_rw) ram[mem_addr] <= mem_data;
  end

  function automatic int ref_pat(input int a, input int s);
    return ((a * 2 + 2) % 256) ^ s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_test(input logic [DW-1:0] s, input bit exp_pass,
                          input int exp_ea, input int exp_ed,
                          input bit poke);
    int cyc = 1;
    int wr_cnt = 0;
    int wr_ord = 0;
    int wr_bad = 0;
    int busy_bad = 0;
    int pass_bad = 0;
    int extra_done = 0;
    int wlog [DEP];
    for (int i = 0; i < DEP; i++) wlog[i] = -1;
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seed  = DW'($urandom);
    while (!done && cyc < 400) begin
      if (!busy) busy_bad++;
      if (pass) pass_bad++;
      if (mem_rw) begin
        wlog[mem_addr] = int'(mem_data);
        wr_cnt++;
        if (cyc != int'(mem_addr) + 1) wr_ord++;
      end
      start = poke && (cyc == 40);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    for (int a = 0; a < DEP; a++)
      if (wlog[a] != ref_pat(a, int'(s))) wr_bad++;
    chk("done_cycle", cyc, 130);
    chk("busy_in_run", busy_bad, 0);
    chk("pass_cleared", pass_bad, 0);
    chk("wr_count", wr_cnt, DEP);
    chk("wr_order", wr_ord, 0);
    chk("wr_data", wr_bad, 0);
    chk("wr_a0", wlog[0], ref_pat(0, int'(s)));
    chk("wr_a5", wlog[5], ref_pat(5, int'(s)));
    chk("wr_a63", wlog[63], ref_pat(63, int'(s)));
    chk("busy_at_done", busy, 1);
    chk("pass", pass, exp_pass);
`ifdef ERR_CAPTURE_EN
    chk("err_addr", err_addr, exp_ea);
    chk("err_data", err_data, exp_ed);
`else
    if (exp_ea < 0 || exp_ed < 0) chk("err_arg", 1, 0);
`endif
    @(negedge clk);
    if (done) extra_done++;
    chk("done_one_cycle", extra_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_addr", mem_addr, 0);
    chk("pass_hold", pass, exp_pass);
  endtask

  task automatic run_abort(input logic [DW-1:0] s);
    int dn = 0;
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 70; c++) begin
      if (done) dn++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rw", mem_rw, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_pass", pass, 0);
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst_n = 1'b1;
    repeat (140) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
  endtask

  initial begin
    int s;
    int fa;
    int fb;
    bit fault;
    for (int i = 0; i < DEP; i++) ram[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_rw", mem_rw, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_data", mem_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_test(8'h00, 1'b1, 0, 0, 1'b0);
    run_test(8'hFF, 1'b1, 0, 0, 1'b0);

    stuck0 = 1'b1;
    run_test(8'h00, 1'b0, 0, 8'h03, 1'b0);
    stuck0 = 1'b0;

    run_test(8'h5A, 1'b1, 0, 0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      s     = int'($urandom_range(255, 0));
      fault = bit'($urandom_range(1, 0));
      fa    = int'($urandom_range(DEP - 1, 0));
      fb    = int'($urandom_range(DW - 1, 0));
      flip_en   = fault;
      flip_addr = AW'(fa);
      flip_mask = DW'(1 << fb);
      if (fault)
        run_test(DW'(s), 1'b0, fa, ref_pat(fa, s) ^ (1 << fb), 1'b0);
      else
        run_test(DW'(s), 1'b1, 0, 0, 1'b0);
      flip_en = 1'b0;
    end

    run_abort(8'h33);
    run_test(8'hC3, 1'b1, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
